// File: rtl/regfile_wb.sv
// regfile_wb: writeback stage and architectural register file.
//
// Commits the writeback result into a 32-entry integer register file. x0 has no storage and
// always reads zero. Two combinational read ports serve decode. A 64-bit retired-instruction
// counter and the last retired instruction word are kept for the debug/trace path.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears registers, counter, last instruction)
//   i_inst     instruction in writeback, all-zero word is a bubble
//   i_rd       destination register index
//   i_regWEn   register write enable
//   i_wbData   result to commit
//   i_rs1/2    read addresses from decode
//   o_rs1/2Data read data (combinational)
//   o_instret  retired-instruction count, wraps modulo 2^64
//   o_lastInst most recently retired instruction word
//
// Optional feature: define REGFILE_BYPASS_EN to forward i_wbData to a read port addressing the
// register being written in the same cycle. Without it, reads see the pre-write contents.

module regfile_wb #(
  parameter int unsigned INST_LENGTH     = 32,
  parameter int unsigned REG_ADDR_LENGTH = 5,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_LENGTH-1:0]     i_inst,
  input  logic [REG_ADDR_LENGTH-1:0] i_rd,
  input  logic                       i_regWEn,
  input  logic [DATA_WIDTH-1:0]      i_wbData,
  input  logic [REG_ADDR_LENGTH-1:0] i_rs1,
  input  logic [REG_ADDR_LENGTH-1:0] i_rs2,
  output logic [DATA_WIDTH-1:0]      o_rs1Data,
  output logic [DATA_WIDTH-1:0]      o_rs2Data,
  output logic [63:0]                o_instret,
  output logic [INST_LENGTH-1:0]     o_lastInst
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_LENGTH;

  // Entry 0 is intentionally absent; x0 is a hard-wired zero.
  logic [DATA_WIDTH-1:0]  regs_q [1:NumRegs-1];
  logic [63:0]            instret_q;
  logic [INST_LENGTH-1:0] last_inst_q;

  logic                   retire;
  logic [DATA_WIDTH-1:0]  rs1_data;
  logic [DATA_WIDTH-1:0]  rs2_data;

  // Retirement is decided by the instruction word alone, so stores and branches count too.
  assign retire = (i_inst != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      instret_q   <= '0;
      last_inst_q <= '0;
    end else begin
      // i never equals 0, so a write addressed to x0 matches no entry and is dropped.
      for (int unsigned i = 1; i < NumRegs; i++) begin
        if (i_regWEn && (i_rd == REG_ADDR_LENGTH'(i))) begin
          regs_q[i] <= i_wbData;
        end
      end
      if (retire) begin
        instret_q   <= instret_q + 64'd1;
        last_inst_q <= i_inst;
      end
    end
  end

  // Read mux: address 0 matches no stored entry and falls through to the zero default.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      if (i_rs1 == REG_ADDR_LENGTH'(i)) begin
        rs1_data = regs_q[i];
      end
      if (i_rs2 == REG_ADDR_LENGTH'(i)) begin
        rs2_data = regs_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding; suppressed during reset because that write will be discarded.
    if (!rst && i_regWEn && (i_rd != '0)) begin
      if (i_rs1 == i_rd) begin
        rs1_data = i_wbData;
      end
      if (i_rs2 == i_rd) begin
        rs2_data = i_wbData;
      end
    end
`endif
  end

  assign o_rs1Data  = rs1_data;
  assign o_rs2Data  = rs2_data;
  assign o_instret  = instret_q;
  assign o_lastInst = last_inst_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: a directed vector table plus hand-written sequences for
// reset, bypass, reset-versus-event priority and counter wrap. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.

module tb_regfile_wb;

  logic        clk;
  logic        rst;
  logic [31:0] i_inst;
  logic [4:0]  i_rd;
  logic        i_regWEn;
  logic [31:0] i_wbData;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] o_rs1Data;
  logic [31:0] o_rs2Data;
  logic [63:0] o_instret;
  logic [31:0] o_lastInst;

  int n_vec;
  int n_err;

  regfile_wb dut (
    .clk        (clk),
    .rst        (rst),
    .i_inst     (i_inst),
    .i_rd       (i_rd),
    .i_regWEn   (i_regWEn),
    .i_wbData   (i_wbData),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .o_rs1Data  (o_rs1Data),
    .o_rs2Data  (o_rs2Data),
    .o_instret  (o_instret),
    .o_lastInst (o_lastInst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wb;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [63:0] e_instret;
    logic [31:0] e_last;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] model [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: wait for the falling edge, drive inputs, settle before sampling.
  task automatic step(input logic r, input logic [31:0] inst, input logic [4:0] rd,
                      input logic wen, input logic [31:0] wb,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    @(negedge clk);
    rst      = r;
    i_inst   = inst;
    i_rd     = rd;
    i_regWEn = wen;
    i_wbData = wb;
    i_rs1    = rs1;
    i_rs2    = rs2;
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    i_inst   = '0;
    i_rd     = '0;
    i_regWEn = 1'b0;
    i_wbData = '0;
    i_rs1    = '0;
    i_rs2    = '0;

    // Expected outputs are those visible before the rising edge of the same cycle.
    vecs[0] = '{32'h0050_0293, 5'd5,  1'b1, 32'hDEAD_BEEF, 5'd0,  5'd0,
                32'h0,         32'h0,         64'd0, 32'h0};
    vecs[1] = '{32'h0,         5'd5,  1'b0, 32'h0,         5'd5,  5'd5,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 64'd1, 32'h0050_0293};
    vecs[2] = '{32'h0100_0013, 5'd0,  1'b1, 32'h0000_1234, 5'd0,  5'd5,
                32'h0,         32'hDEAD_BEEF, 64'd1, 32'h0050_0293};
    vecs[3] = '{32'h0,         5'd0,  1'b0, 32'h0,         5'd0,  5'd0,
                32'h0,         32'h0,         64'd2, 32'h0100_0013};
    vecs[4] = '{32'h0052_A023, 5'd5,  1'b0, 32'hFFFF_FFFF, 5'd5,  5'd6,
                32'hDEAD_BEEF, 32'h0,         64'd2, 32'h0100_0013};
    vecs[5] = '{32'h0,         5'd6,  1'b1, 32'h1111_2222, 5'd5,  5'd0,
                32'hDEAD_BEEF, 32'h0,         64'd3, 32'h0052_A023};
    vecs[6] = '{32'h0010_8093, 5'd6,  1'b0, 32'h0,         5'd6,  5'd5,
                32'h1111_2222, 32'hDEAD_BEEF, 64'd3, 32'h0052_A023};
    vecs[7] = '{32'h0,         5'd0,  1'b0, 32'h0,         5'd31, 5'd6,
                32'h0,         32'h1111_2222, 64'd4, 32'h0010_8093};
    vecs[8] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 32'h8000_0001, 5'd1,  5'd2,
                32'h0,         32'h0,         64'd4, 32'h0010_8093};
    vecs[9] = '{32'h0,         5'd0,  1'b0, 32'h0,         5'd31, 5'd31,
                32'h8000_0001, 32'h8000_0001, 64'd5, 32'hFFFF_FFFF};

    // Initial reset.
    step(1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
    step(1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
    check("reset_instret", o_instret, 64'd0);
    check("reset_lastinst", {32'h0, o_lastInst}, 64'd0);

    for (int v = 0; v < 10; v++) begin
      step(1'b0, vecs[v].inst, vecs[v].rd, vecs[v].wen, vecs[v].wb, vecs[v].rs1, vecs[v].rs2);
      check($sformatf("vec%0d_rs1", v), {32'h0, o_rs1Data}, {32'h0, vecs[v].e_rs1});
      check($sformatf("vec%0d_rs2", v), {32'h0, o_rs2Data}, {32'h0, vecs[v].e_rs2});
      check($sformatf("vec%0d_instret", v), o_instret, vecs[v].e_instret);
      check($sformatf("vec%0d_last", v), {32'h0, o_lastInst}, {32'h0, vecs[v].e_last});
    end

    // Random fill of x1..x31, then read back every register on both ports.
    model[0] = '0;
    for (int i = 1; i < 32; i++) begin
      model[i] = $urandom;
      step(1'b0, 32'h0, 5'(i), 1'b1, model[i], 5'd0, 5'd0);
    end
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'(i), 5'((i % 31) + 1));
      check($sformatf("fill_rs1_x%0d", i), {32'h0, o_rs1Data}, {32'h0, model[i]});
      check($sformatf("fill_rs2_x%0d", i), {32'h0, o_rs2Data}, {32'h0, model[(i % 31) + 1]});
    end

    // Bypass: x7 holds 1, then written with A5A5A5A5 while port 2 reads it.
    step(1'b0, 32'h0, 5'd7, 1'b1, 32'h1, 5'd0, 5'd0);
    model[7] = 32'h1;
    step(1'b0, 32'h0, 5'd7, 1'b1, 32'hA5A5_A5A5, 5'd5, 5'd7);
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", {32'h0, o_rs2Data}, {32'h0, 32'hA5A5_A5A5});
`else
    check("bypass_same_cycle", {32'h0, o_rs2Data}, {32'h0, 32'h1});
`endif
    check("bypass_other_port", {32'h0, o_rs1Data}, {32'h0, model[5]});
    model[7] = 32'hA5A5_A5A5;
    step(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd7);
    check("bypass_next_cycle", {32'h0, o_rs2Data}, {32'h0, 32'hA5A5_A5A5});

    // Reset coinciding with a write to x3 and a retiring instruction; no bypass during reset.
    step(1'b1, 32'h0090_0193, 5'd3, 1'b1, 32'h9, 5'd3, 5'd7);
    check("rst_no_bypass_rs1", {32'h0, o_rs1Data}, {32'h0, model[3]});
    check("rst_rs2_array", {32'h0, o_rs2Data}, {32'h0, 32'hA5A5_A5A5});
    step(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd3, 5'd0);
    check("rst_event_x3", {32'h0, o_rs1Data}, 64'd0);
    check("rst_event_instret", o_instret, 64'd0);
    check("rst_event_lastinst", {32'h0, o_lastInst}, 64'd0);
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'(i), 5'(32 - i));
      check($sformatf("rst_zero_rs1_x%0d", i), {32'h0, o_rs1Data}, 64'd0);
      check($sformatf("rst_zero_rs2_x%0d", 32 - i), {32'h0, o_rs2Data}, 64'd0);
    end

    // First retirement after reset counts from 1.
    step(1'b0, 32'h0040_0113, 5'd2, 1'b1, 32'h4, 5'd0, 5'd0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd2, 5'd0);
    check("post_rst_instret", o_instret, 64'd1);
    check("post_rst_lastinst", {32'h0, o_lastInst}, {32'h0, 32'h0040_0113});
    check("post_rst_x2", {32'h0, o_rs1Data}, 64'd4);

    // Counter wrap: preload all-ones, then retire once.
    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    check("wrap_preload", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 32'h0000_0033, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
    check("wrap_instret", o_instret, 64'd0);
    check("wrap_lastinst", {32'h0, o_lastInst}, {32'h0, 32'h0000_0033});
    // A bubble after the wrap must hold both outputs.
    step(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
    check("bubble_hold_instret", o_instret, 64'd0);
    check("bubble_hold_lastinst", {32'h0, o_lastInst}, {32'h0, 32'h0000_0033});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Writeback stage and architectural register file for the RISC-V pipeline. Consumes the instruction, destination register and write-enable leaving the last execute pipeline register, together with the final result. It commits the result into a 32-entry register file and serves the two combinational read ports used by decode. It also keeps a 64-bit retired-instruction counter and the last retired instruction word for the debug/trace path.

## Interface
- INST_LENGTH, 32, instruction word width
- REG_ADDR_LENGTH, 5, register address width (2^5 = 32 entries)
- DATA_WIDTH, 32, register data width

- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset, sampled on posedge clk
- i_inst  input  INST_LENGTH  instruction in writeback; 32'h0000_0000 = bubble
- i_rd  input  REG_ADDR_LENGTH  destination register index
- i_regWEn  input  1  register write enable
- i_wbData  input  DATA_WIDTH  result to commit
- i_rs1, i_rs2  input  REG_ADDR_LENGTH  read addresses from decode
- o_rs1Data, o_rs2Data  output  DATA_WIDTH  read data
- o_instret  output  64  retired-instruction count
- o_lastInst  output  INST_LENGTH  most recent retired instruction

## Operation
- Storage is regs[1..31], each DATA_WIDTH wide. x0 has no storage and always reads 0.
- Write: on posedge clk with rst=0, i_regWEn=1 and i_rd≠0, regs[i_rd] ← i_wbData.
  - A write to x0 is silently dropped.
  - i_regWEn=0 leaves the array unchanged, whatever i_rd is.
- Read: combinational.
  - o_rsNData = 0 if i_rsN=0, else regs[i_rsN] (bypass rules under Configuration).
  - Both ports may address the same register; both then return the same value.
- Retire: a cycle retires when i_inst≠0, independent of i_regWEn, so stores and branches count.
  - On a retiring posedge with rst=0: o_instret ← o_instret+1 (mod 2^64, wraps to 0 past all-ones) and o_lastInst ← i_inst.
  - Bubble cycles hold both outputs.
- Reset: on posedge clk with rst=1:
  - regs[1..31] ← 0, o_instret ← 0, o_lastInst ← 0.
  - Any write or retire presented in that cycle is discarded; reset wins over a simultaneous event.
- Reset in mid-stream: the first retiring cycle after rst deasserts produces o_instret=1.

## Timing
- Write latency: 1 edge. Data presented in cycle N is visible on the read ports from cycle N+1 without bypass.
- Read latency: 0 cycles (combinational from address and array).
- o_instret and o_lastInst are registered and update 1 edge after the retiring cycle.
- No handshake: each cycle's inputs are consumed unconditionally; stalls are expressed upstream as bubbles.
- Reset values: o_instret=0, o_lastInst=0. o_rs1Data and o_rs2Data read 0 for every address after reset.

## Configuration
- Macro REGFILE_BYPASS_EN controls same-cycle write-to-read bypass.
- Defined: when i_regWEn=1, i_rd≠0 and i_rsN=i_rd, o_rsNData = i_wbData in the same cycle. This removes the WB→ID hazard. The bypass is inactive while rst=1.
- Undefined: reads return the pre-write array contents in that cycle. Hazard logic upstream must stall one cycle.

## Test plan
- Reset: assert rst 1 cycle after random writes. Expect all 31 registers to read 0, o_instret=0 and o_lastInst=0.
- Write/read: write x5=32'hDEAD_BEEF, then set i_rs1=5 and i_rs2=5 next cycle. Expect both ports = 32'hDEAD_BEEF. A write of 32'h1234 to x0 must leave x0 reading 0.
- Bypass: same cycle, i_regWEn=1, i_rd=7, i_wbData=32'hA5A5_A5A5, i_rs2=7, x7 previously 1.
  - With REGFILE_BYPASS_EN: o_rs2Data=32'hA5A5_A5A5.
  - Without the macro: o_rs2Data=1 that cycle and 32'hA5A5_A5A5 the next.
- Retire counting: 3 real instructions and 2 bubbles (i_inst=0), one of them a store with i_regWEn=0. Expect o_instret=3 and o_lastInst = the third instruction word.
- Counter wrap: force o_instret to 64'hFFFF_FFFF_FFFF_FFFF, then retire one instruction. Expect o_instret=0.
- Reset versus simultaneous events: assert rst together with a write to x3=9 and a retiring instruction. Expect x3=0, o_instret=0 and o_lastInst=0.
